// File: rtl/cond_logic_it.sv
// cond_logic_it
//   Conditional-execution unit between decoder and datapath. Holds the NZCV
//   flags, evaluates the condition field, and gates PCSrc/RegWrite/MemWrite.
//   Bubbles (Valid=0) freeze all state. Thumb-style IT blocks predicate the
//   next 1..IT_DEPTH valid instructions with then/else variants of one base
//   condition.
// Ports
//   CLK, reset        : clock (rising edge), async active-low reset
//   Valid             : instruction is real
//   PCS/RegW/MemW     : decoder write requests
//   NoWrite           : compare-class, suppresses RegWrite
//   FlagW[1:0]        : [1] loads N,Z  [0] loads C,V
//   ALUFlags          : {N,Z,C,V} from ALU
//   Cond              : instruction condition field
//   ITStart/ITCond/ITLen/ITMask : IT instruction fields
//   PCSrc/RegWrite/MemWrite     : gated writes
//   CondEx            : condition passed (and Valid)
//   Flags             : registered {N,Z,C,V}
//   ITActive/ITRemain : IT block in progress / slots left
//   ITErr             : sticky malformed-IT flag
module cond_logic_it #(
   parameter int IT_DEPTH = 4,
   parameter int LEN_W    = $clog2(IT_DEPTH + 1)
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                Valid,
   input  logic                PCS,
   input  logic                RegW,
   input  logic                MemW,
   input  logic                NoWrite,
   input  logic [1:0]          FlagW,
   input  logic [3:0]          ALUFlags,
   input  logic [3:0]          Cond,
   input  logic                ITStart,
   input  logic [3:0]          ITCond,
   input  logic [LEN_W-1:0]    ITLen,
   input  logic [IT_DEPTH-1:0] ITMask,
   output logic                PCSrc,
   output logic                RegWrite,
   output logic                MemWrite,
   output logic                CondEx,
   output logic [3:0]          Flags,
   output logic                ITActive,
   output logic [LEN_W-1:0]    ITRemain,
   output logic                ITErr
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(IT_DEPTH);

   state_t              state_q, state_d;
   logic [3:0]          flags_q, flags_d;
   logic [3:0]          it_cond_q, it_cond_d;
   logic [IT_DEPTH-1:0] mask_q, mask_d;
   logic [LEN_W-1:0]    slot_q, slot_d;
   logic [LEN_W-1:0]    remain_q, remain_d;
   logic                err_q, err_d;

   logic       mask_bit;
   logic [3:0] ec;
   logic       pass;
   logic       it_instr;
   logic       len_ok;
   logic       n_f, z_f, c_f, v_f;

   assign {n_f, z_f, c_f, v_f} = flags_q;

   // Effective condition: inside an IT block the base condition is flipped
   // in its LSB for "else" slots, except for AL where flipping would give
   // the 1111 encoding rather than a true inverse.
   always_comb begin
      mask_bit = 1'b0;
      for (int i = 0; i < IT_DEPTH; i++)
         if (slot_q == LEN_W'(i)) mask_bit = mask_q[i];
      ec = Cond;
      if (state_q == ACTIVE) begin
         ec = it_cond_q;
         if (it_cond_q != 4'b1110) ec[0] = it_cond_q[0] ^ mask_bit;
      end
   end

   always_comb begin
      pass = 1'b1;
      case (ec)
         4'b0000: pass = z_f;
         4'b0001: pass = !z_f;
         4'b0010: pass = c_f;
         4'b0011: pass = !c_f;
         4'b0100: pass = n_f;
         4'b0101: pass = !n_f;
         4'b0110: pass = v_f;
         4'b0111: pass = !v_f;
         4'b1000: pass = c_f & !z_f;
         4'b1001: pass = !c_f | z_f;
         4'b1010: pass = (n_f == v_f);
         4'b1011: pass = (n_f != v_f);
         4'b1100: pass = !z_f & (n_f == v_f);
         4'b1101: pass = z_f | (n_f != v_f);
         default: pass = 1'b1;
      endcase
   end

   // An IT instruction only opens a block from IDLE; inside a block it is an
   // ordinary predicated slot.
   assign it_instr = Valid & ITStart & (state_q == IDLE);
   assign len_ok   = (ITLen != '0) && (ITLen <= DEPTH_L);

   assign CondEx   = Valid & pass;
   assign PCSrc    = PCS  & CondEx & !it_instr;
   assign RegWrite = RegW & CondEx & !NoWrite & !it_instr;
   assign MemWrite = MemW & CondEx & !it_instr;

   always_comb begin
      state_d   = state_q;
      flags_d   = flags_q;
      it_cond_d = it_cond_q;
      mask_d    = mask_q;
      slot_d    = slot_q;
      remain_d  = remain_q;
      err_d     = err_q;

      if (FlagW[1] & CondEx & !it_instr) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0] & CondEx & !it_instr) flags_d[1:0] = ALUFlags[1:0];

      case (state_q)
         IDLE: begin
            if (it_instr) begin
               if (len_ok) begin
                  state_d   = ACTIVE;
                  it_cond_d = ITCond;
                  mask_d    = ITMask;
                  mask_d[0] = 1'b0;   // slot 0 is always "then"
                  slot_d    = '0;
                  remain_d  = ITLen;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (Valid) begin
               if (ITStart) err_d = 1'b1;
               // A taken branch leaves the block; remaining slots are dropped.
               if (PCSrc || remain_q == LEN_W'(1)) begin
                  state_d  = IDLE;
                  slot_d   = '0;
                  remain_d = '0;
               end else begin
                  slot_d   = slot_q + LEN_W'(1);
                  remain_d = remain_q - LEN_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         flags_q   <= '0;
         it_cond_q <= '0;
         mask_q    <= '0;
         slot_q    <= '0;
         remain_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         it_cond_q <= it_cond_d;
         mask_q    <= mask_d;
         slot_q    <= slot_d;
         remain_q  <= remain_d;
         err_q     <= err_d;
      end
   end

   assign Flags    = flags_q;
   assign ITActive = (state_q == ACTIVE);
   assign ITRemain = remain_q;
   assign ITErr    = err_q;

endmodule

// File: tb/tb_cond_logic_it.sv
// Directed-vector bench for cond_logic_it. Each vector is driven just after
// a rising edge and its hand-computed expectation is queued; a monitor on
// the falling edge pops and compares.
module tb_cond_logic_it;

   localparam int IT_DEPTH = 4;
   localparam int LEN_W    = 3;

   logic                CLK = 1'b0;
   logic                reset = 1'b0;
   logic                Valid = 1'b0, PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
   logic [1:0]          FlagW = '0;
   logic [3:0]          ALUFlags = '0, Cond = '0, ITCond = '0;
   logic                ITStart = 1'b0;
   logic [LEN_W-1:0]    ITLen = '0;
   logic [IT_DEPTH-1:0] ITMask = '0;
   logic                PCSrc, RegWrite, MemWrite, CondEx, ITActive, ITErr;
   logic [3:0]          Flags;
   logic [LEN_W-1:0]    ITRemain;

   cond_logic_it #(.IT_DEPTH(IT_DEPTH)) dut (
      .CLK(CLK), .reset(reset), .Valid(Valid), .PCS(PCS), .RegW(RegW),
      .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW), .ALUFlags(ALUFlags),
      .Cond(Cond), .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen),
      .ITMask(ITMask), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .CondEx(CondEx), .Flags(Flags), .ITActive(ITActive), .ITRemain(ITRemain),
      .ITErr(ITErr)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int               id;
      logic [3:0]       outs;   // {PCSrc,RegWrite,MemWrite,CondEx}
      logic [3:0]       flags;
      logic             act;
      logic [LEN_W-1:0] rem;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   vid   = 0;

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [3:0] got;
         e   = exp_q.pop_front();
         got = {PCSrc, RegWrite, MemWrite, CondEx};
         n_vec++;
         if (got !== e.outs || Flags !== e.flags || ITActive !== e.act ||
             ITRemain !== e.rem || ITErr !== e.err) begin
            n_bad++;
            $display("FAIL vec%0d: got outs=%b flags=%b act=%b rem=%0d err=%b, want outs=%b flags=%b act=%b rem=%0d err=%b",
                     e.id, got, Flags, ITActive, ITRemain, ITErr,
                     e.outs, e.flags, e.act, e.rem, e.err);
         end
      end
   end

   task automatic vec(input logic rst, v, pcs, rw, mw, nw, input logic [1:0] fw,
                      input logic [3:0] alu, cnd, input logic its, input logic [3:0] itc,
                      input logic [LEN_W-1:0] itl, input logic [IT_DEPTH-1:0] itm,
                      input logic [3:0] e_outs, e_fl, input logic e_act,
                      input logic [LEN_W-1:0] e_rem, input logic e_err);
      exp_t e;
      @(posedge CLK);
      #1;
      reset = rst; Valid = v; PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
      FlagW = fw; ALUFlags = alu; Cond = cnd; ITStart = its; ITCond = itc;
      ITLen = itl; ITMask = itm;
      e.id = vid; e.outs = e_outs; e.flags = e_fl; e.act = e_act;
      e.rem = e_rem; e.err = e_err;
      exp_q.push_back(e);
      vid++;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      //   rst v pcs rw mw nw fw     alu      cond     its itc      itl itm        PRMC     flags   act rem err
      vec(1,0,0,0,0,0,2'b00,4'b0000,4'b0000,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0000,0,3'd0,0); // reset state
      vec(1,1,0,0,0,0,2'b11,4'b0100,4'b0000,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0000,0,3'd0,0); // EQ fails, no flag write
      vec(1,1,0,0,0,0,2'b11,4'b0100,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0001,4'b0000,0,3'd0,0); // AL writes flags
      vec(1,1,0,1,0,1,2'b00,4'b0000,4'b0000,0,4'b0000,3'd0,4'b0000, 4'b0001,4'b0100,0,3'd0,0); // NoWrite
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b0000,0,4'b0000,3'd0,4'b0000, 4'b0101,4'b0100,0,3'd0,0); // RegWrite
      vec(1,1,1,0,1,0,2'b00,4'b0000,4'b0000,0,4'b0000,3'd0,4'b0000, 4'b1011,4'b0100,0,3'd0,0); // PCS+MemW pass
      vec(1,1,1,0,1,0,2'b00,4'b0000,4'b0001,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,0,3'd0,0); // NE fails
      // IT EQ len3 mask 0010; the IT instr itself must not write flags
      vec(1,1,0,1,0,0,2'b11,4'b0000,4'b1110,1,4'b0000,3'd3,4'b0010, 4'b0001,4'b0100,0,3'd0,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0101,4'b0100,1,3'd3,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,1,3'd2,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0101,4'b0100,1,3'd1,0);
      vec(1,0,0,0,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,0,3'd0,0);
      // IT NE len4 mask 0100 with bubbles
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,1,4'b0001,3'd4,4'b0100, 4'b0001,4'b0100,0,3'd0,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,1,3'd4,0);
      vec(1,0,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,1,3'd3,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,1,3'd3,0);
      vec(1,0,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,1,3'd2,0);
      vec(1,0,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,1,3'd2,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0101,4'b0100,1,3'd2,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,1,3'd1,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b0001,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,0,3'd0,0);
      // IT AL len4 mask 1111 (XOR suppressed), branch in slot 1 ends block
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b1110,1,4'b1110,3'd4,4'b1111, 4'b0001,4'b0100,0,3'd0,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b0001,0,4'b0000,3'd0,4'b0000, 4'b0101,4'b0100,1,3'd4,0);
      vec(1,1,1,0,0,0,2'b00,4'b0000,4'b0001,0,4'b0000,3'd0,4'b0000, 4'b1001,4'b0100,1,3'd3,0);
      vec(1,1,0,1,0,0,2'b00,4'b0000,4'b0001,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0100,0,3'd0,0);
      // IT EQ len2: slot0 clears Z, slot1 sees it
      vec(1,1,0,0,0,0,2'b00,4'b0000,4'b1110,1,4'b0000,3'd2,4'b0000, 4'b0001,4'b0100,0,3'd0,0);
      vec(1,1,0,0,1,0,2'b10,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0011,4'b0100,1,3'd2,0);
      vec(1,1,0,0,1,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0000,1,3'd1,0);
      // nested IT start inside a block
      vec(1,1,0,0,0,0,2'b00,4'b0000,4'b1110,1,4'b1110,3'd3,4'b0000, 4'b0001,4'b0000,0,3'd0,0);
      vec(1,1,0,1,0,0,2'b11,4'b1111,4'b0000,1,4'b0000,3'd1,4'b0000, 4'b0101,4'b0000,1,3'd3,0);
      vec(1,1,0,0,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0001,4'b1111,1,3'd2,1);
      // async reset mid-block, checked before any rising edge
      vec(0,0,0,0,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0000,0,3'd0,0);
      // bad IT lengths
      vec(1,1,0,0,0,0,2'b00,4'b0000,4'b1110,1,4'b0000,3'd0,4'b0000, 4'b0001,4'b0000,0,3'd0,0);
      vec(1,1,0,0,0,0,2'b00,4'b0000,4'b1110,1,4'b0000,3'd5,4'b0000, 4'b0001,4'b0000,0,3'd0,1);
      vec(1,0,0,0,0,0,2'b00,4'b0000,4'b1110,0,4'b0000,3'd0,4'b0000, 4'b0000,4'b0000,0,3'd0,1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
      if (exp_q.size() > 0) begin
         n_bad += exp_q.size();
         $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
